// File: rtl/adc_acq_pkg.sv
// Shared definitions for the ADC acquisition sequencer.
//   acq_state_e : sequencer FSM states
//   DEF_DATA_W  : default ADC sample width
//   OVR_W/SCNT_W: widths of the overrun and sample counters
//   cnt_w()     : width needed to hold values 0..n-1 (minimum 1 bit)
package adc_acq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_PUSH  = 2'd3
    } acq_state_e;

    localparam int DEF_DATA_W = 24;
    localparam int OVR_W      = 16;
    localparam int SCNT_W     = 32;

    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/adc_period_tick.sv
// Sample-period pacer. Free-runs 0..PERIOD-1 while enabled and emits a
// one-cycle tick on the last count; held at 0 while disabled so the first
// tick after enabling lands PERIOD-1 cycles later.
//   i_clk  : system clock
//   i_rst  : asynchronous reset, active-low
//   i_en   : enable counting
//   o_tick : one-cycle tick (combinational from the count)
module adc_period_tick
    import adc_acq_pkg::*;
#(
    parameter int PERIOD = 1000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    output logic o_tick
);

    localparam int              CW   = cnt_w(PERIOD);
    localparam logic [CW-1:0]   LAST = CW'(PERIOD - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            cnt <= '0;
        end else if (!i_en || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign o_tick = i_en && (cnt == LAST);

endmodule

// File: rtl/adc_acq_sequencer.sv
// ADC acquisition sequencer for one channel. On every period tick it pulses
// a conversion start, waits (bounded by TIMEOUT) for the SPI read to finish
// and forwards the word as a one-cycle push into the moving-sum datapath.
//   i_clk/i_rst      : clock, asynchronous active-low reset
//   i_en             : enable periodic sampling
//   i_flush          : restart window fill count
//   i_err_clr        : clear sticky o_timeout
//   o_cnv_start      : one-cycle conversion start pulse
//   i_spi_done       : read complete, i_spi_data valid
//   i_spi_data       : raw ADC word
//   o_adc_data       : last pushed sample (held between pushes)
//   o_adc_valid      : one-cycle push strobe
//   o_window_full    : moving sum covers WINDOW real samples
//   o_timeout        : sticky wait timeout flag
//   o_overrun_cnt    : ticks dropped while busy (saturating)
//   o_sample_cnt     : total pushes since reset (wrapping)
module adc_acq_sequencer
    import adc_acq_pkg::*;
#(
    parameter int SAMPLE_PERIOD = 1000,
    parameter int TIMEOUT       = 200,
    parameter int WINDOW        = 16,
    parameter int DATA_W        = DEF_DATA_W
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_en,
    input  logic              i_flush,
    input  logic              i_err_clr,
    output logic              o_cnv_start,
    input  logic              i_spi_done,
    input  logic [DATA_W-1:0] i_spi_data,
    output logic [DATA_W-1:0] o_adc_data,
    output logic              o_adc_valid,
    output logic              o_window_full,
    output logic              o_timeout,
    output logic [OVR_W-1:0]  o_overrun_cnt,
    output logic [SCNT_W-1:0] o_sample_cnt
);

    localparam int                WCNT_W    = cnt_w(TIMEOUT);
    localparam int                FILL_W    = cnt_w(WINDOW + 2);
    localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(TIMEOUT - 1);
    localparam logic [FILL_W-1:0] FILL_MAX  = FILL_W'(WINDOW + 1);
    localparam logic [FILL_W-1:0] FULL_AT   = FILL_W'(WINDOW);

    acq_state_e        state;
    logic [WCNT_W-1:0] wait_cnt;
    logic [FILL_W-1:0] fill_cnt;
    logic              tick;

    adc_period_tick #(.PERIOD(SAMPLE_PERIOD)) u_tick (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_en   (i_en),
        .o_tick (tick)
    );

    // Sequencer FSM. o_adc_data doubles as the latch for the SPI word, so the
    // value pushed in PUSH stays visible until the next push.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state         <= ST_IDLE;
            wait_cnt      <= '0;
            o_cnv_start   <= 1'b0;
            o_adc_valid   <= 1'b0;
            o_adc_data    <= '0;
            o_timeout     <= 1'b0;
            o_overrun_cnt <= '0;
        end else begin
            o_cnv_start <= 1'b0;
            o_adc_valid <= 1'b0;
            if (i_err_clr) o_timeout <= 1'b0;
            // A tick is only honoured in IDLE; otherwise it is lost and counted.
            if (tick && state != ST_IDLE && o_overrun_cnt != '1)
                o_overrun_cnt <= o_overrun_cnt + 1'b1;
            unique case (state)
                ST_IDLE: begin
                    if (tick) begin
                        state       <= ST_START;
                        o_cnv_start <= 1'b1;
                    end
                end
                ST_START: begin
                    state    <= ST_WAIT;
                    wait_cnt <= '0;
                end
                ST_WAIT: begin
                    // done beats a timeout landing in the same cycle
                    if (i_spi_done) begin
                        state       <= ST_PUSH;
                        o_adc_valid <= 1'b1;
                        o_adc_data  <= i_spi_data;
                    end else if (wait_cnt == WAIT_LAST) begin
                        state     <= ST_IDLE;
                        o_timeout <= 1'b1;   // after err_clr above: set wins
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ST_PUSH: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Push bookkeeping runs in the PUSH cycle (o_adc_valid high). The datapath
    // sum lags one push, so "full" needs WINDOW+1 pushes.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            fill_cnt      <= '0;
            o_window_full <= 1'b0;
            o_sample_cnt  <= '0;
        end else begin
            if (o_adc_valid) o_sample_cnt <= o_sample_cnt + 1'b1;
            if (i_flush) begin
                fill_cnt      <= '0;
                o_window_full <= 1'b0;
            end else if (o_adc_valid && fill_cnt != FILL_MAX) begin
                fill_cnt      <= fill_cnt + 1'b1;
                o_window_full <= (fill_cnt == FULL_AT);
            end
        end
    end

endmodule

// File: tb/tb_adc_acq_sequencer.sv
module tb_adc_acq_sequencer;

    localparam int P = 20;
    localparam int W = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  en, flush, err_clr, done;
    logic [23:0] data [2];
    logic        cnv [2], valid [2], full [2], tout [2];
    logic [23:0] adata [2];
    logic [15:0] ovr [2];
    logic [31:0] scnt [2];

    always #5 clk = ~clk;

    adc_acq_sequencer #(.SAMPLE_PERIOD(P), .TIMEOUT(8), .WINDOW(W), .DATA_W(24)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_en(en[0]), .i_flush(flush[0]), .i_err_clr(err_clr[0]),
        .o_cnv_start(cnv[0]), .i_spi_done(done[0]), .i_spi_data(data[0]),
        .o_adc_data(adata[0]), .o_adc_valid(valid[0]), .o_window_full(full[0]),
        .o_timeout(tout[0]), .o_overrun_cnt(ovr[0]), .o_sample_cnt(scnt[0]));

    adc_acq_sequencer #(.SAMPLE_PERIOD(P), .TIMEOUT(30), .WINDOW(W), .DATA_W(24)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_en(en[1]), .i_flush(flush[1]), .i_err_clr(err_clr[1]),
        .o_cnv_start(cnv[1]), .i_spi_done(done[1]), .i_spi_data(data[1]),
        .o_adc_data(adata[1]), .o_adc_valid(valid[1]), .o_window_full(full[1]),
        .o_timeout(tout[1]), .o_overrun_cnt(ovr[1]), .o_sample_cnt(scnt[1]));

    int vectors, miscompares, cyc;

    // Reference model: a transaction is a start cycle s plus a wait window
    // [s+1, s+T]; the channel is busy until busy_end.
    int          ph [2], s_at [2], busy_end [2], push_at [2], plan_d [2], dmin [2], dmax [2];
    bit          resolved [2];
    logic [23:0] push_data [2], e_data [2];
    logic [31:0] e_cnt [2];
    int          e_ovr [2], fill [2];
    bit          e_start [2], e_valid [2], e_to [2], e_full [2];
    int          spur_pct [2], flush_pct [2], clr_pct [2];
    bit          rand_data [2], flush_on_push [2], clr_on_to [2], flush_now [2], clr_now [2];

    function automatic int tmo(int k);
        return (k != 0) ? 30 : 8;
    endfunction

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s @cyc %0d: observed %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset(int k);
        ph[k] = 0; s_at[k] = -100; resolved[k] = 1; busy_end[k] = 0; push_at[k] = -1;
        push_data[k] = '0; e_data[k] = '0; e_cnt[k] = '0; e_ovr[k] = 0; fill[k] = 0;
        e_start[k] = 0; e_valid[k] = 0; e_to[k] = 0; e_full[k] = 0;
    endtask

    task automatic model_step(int k);
        bit tick;
        int c;
        c = cyc;
        if (!rst) begin
            model_reset(k);
            return;
        end
        tick  = en[k] && ph[k] == P - 1;
        ph[k] = (en[k] && !tick) ? ph[k] + 1 : 0;
        if (c == push_at[k]) begin
            e_cnt[k] = e_cnt[k] + 1;
            fill[k]  = flush[k] ? 0 : ((fill[k] < W + 1) ? fill[k] + 1 : W + 1);
        end else if (flush[k]) begin
            fill[k] = 0;
        end
        if (err_clr[k]) e_to[k] = 0;
        if (!resolved[k] && c >= s_at[k] + 1 && c <= s_at[k] + tmo(k)) begin
            if (done[k]) begin
                push_at[k] = c + 1; push_data[k] = data[k]; busy_end[k] = c + 2; resolved[k] = 1;
            end else if (c == s_at[k] + tmo(k)) begin
                e_to[k] = 1; busy_end[k] = c + 1; resolved[k] = 1;
            end
        end
        if (tick) begin
            if (c >= busy_end[k]) begin
                s_at[k] = c + 1; resolved[k] = 0; busy_end[k] = 32'h7fff_ffff;
                plan_d[k] = $urandom_range(dmax[k], dmin[k]);
            end else if (e_ovr[k] < 65535) begin
                e_ovr[k]++;
            end
        end
        e_start[k] = (s_at[k] == c + 1);
        e_valid[k] = (push_at[k] == c + 1);
        if (e_valid[k]) e_data[k] = push_data[k];
        e_full[k] = (fill[k] == W + 1);
    endtask

    task automatic check_outs(int k);
        string n;
        n = (k != 0) ? "B" : "A";
        chk($sformatf("%s.cnv_start", n), 32'(cnv[k]),   32'(e_start[k]));
        chk($sformatf("%s.adc_valid", n), 32'(valid[k]), 32'(e_valid[k]));
        chk($sformatf("%s.adc_data", n),  32'(adata[k]), 32'(e_data[k]));
        chk($sformatf("%s.window_full", n), 32'(full[k]), 32'(e_full[k]));
        chk($sformatf("%s.timeout", n),   32'(tout[k]),  32'(e_to[k]));
        chk($sformatf("%s.overrun", n),   32'(ovr[k]),   32'(e_ovr[k]));
        chk($sformatf("%s.sample_cnt", n), scnt[k],      e_cnt[k]);
    endtask

    task automatic check_zero(int k);
        string n;
        n = (k != 0) ? "B" : "A";
        chk($sformatf("%s.rst_cnv", n),   32'(cnv[k]),   0);
        chk($sformatf("%s.rst_valid", n), 32'(valid[k]), 0);
        chk($sformatf("%s.rst_data", n),  32'(adata[k]), 0);
        chk($sformatf("%s.rst_full", n),  32'(full[k]),  0);
        chk($sformatf("%s.rst_to", n),    32'(tout[k]),  0);
        chk($sformatf("%s.rst_ovr", n),   32'(ovr[k]),   0);
        chk($sformatf("%s.rst_cnt", n),   scnt[k],       0);
    endtask

    // Drive one cycle of inputs, clock, then compare both DUTs to the model.
    task automatic step();
        logic d;
        for (int k = 0; k < 2; k++) begin
            d = (!resolved[k] && cyc == s_at[k] + plan_d[k]);
            if (spur_pct[k] != 0 && $urandom_range(99, 0) < spur_pct[k]) d = 1'b1;
            done[k]    = d;
            data[k]    = rand_data[k] ? 24'($urandom) : 24'(e_cnt[k] + 1);
            flush[k]   = flush_now[k] || (flush_on_push[k] && cyc == push_at[k]) ||
                         (flush_pct[k] != 0 && $urandom_range(99, 0) < flush_pct[k]);
            err_clr[k] = clr_now[k] || (clr_on_to[k] && cyc == s_at[k] + tmo(k)) ||
                         (clr_pct[k] != 0 && $urandom_range(99, 0) < clr_pct[k]);
            flush_now[k] = 0;
            clr_now[k]   = 0;
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            model_step(k);
            check_outs(k);
        end
        cyc++;
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        vectors = 0; miscompares = 0; cyc = 0;
        rst = 1'b0; en = '0; flush = '0; err_clr = '0; done = '0;
        data[0] = '0; data[1] = '0;
        for (int k = 0; k < 2; k++) begin
            model_reset(k);
            dmin[k] = 3; dmax[k] = 3; plan_d[k] = 3;
            spur_pct[k] = 0; flush_pct[k] = 0; clr_pct[k] = 0;
            rand_data[k] = 0; flush_on_push[k] = 0; clr_on_to[k] = 0;
            flush_now[k] = 0; clr_now[k] = 0;
        end
        #3;
        check_zero(0); check_zero(1);
        run(2);
        rst = 1'b1;

        // 17 regular samples, data = sample number, done 3 clk after start
        en[0] = 1'b1;
        run(360);
        chk("A.cnt_after_17", scnt[0], 17);
        chk("A.full_after_17", 32'(full[0]), 1);
        flush_now[0] = 1;
        step();
        chk("A.full_after_flush", 32'(full[0]), 0);
        chk("A.cnt_after_flush", scnt[0], 17);

        // randomized traffic: delays incl. first WAIT cycle, spurious done, flush/clear
        dmin[0] = 1; dmax[0] = 6; rand_data[0] = 1;
        spur_pct[0] = 5; flush_pct[0] = 3; clr_pct[0] = 3;
        run(400);
        spur_pct[0] = 0; flush_pct[0] = 0; clr_pct[0] = 0;

        // no done at all -> timeout
        dmin[0] = 50; dmax[0] = 50;
        run(40);
        chk("A.timeout_set", 32'(tout[0]), 1);

        // done on the timeout cycle -> push wins, flag stays clear
        dmin[0] = 8; dmax[0] = 8;
        run(20);
        clr_now[0] = 1;
        step();
        chk("A.timeout_clr", 32'(tout[0]), 0);
        run(25);
        chk("A.done_at_limit", 32'(tout[0]), 0);

        // flush coincident with every push
        dmin[0] = 3; dmax[0] = 5;
        flush_on_push[0] = 1;
        run(25);
        chk("A.flush_on_push", 32'(full[0]), 0);
        flush_on_push[0] = 0;

        // err_clr coincident with the timeout
        dmin[0] = 50; dmax[0] = 50; clr_on_to[0] = 1;
        run(40);
        chk("A.set_beats_clr", 32'(tout[0]), 1);
        clr_on_to[0] = 0;
        dmin[0] = 3; dmax[0] = 3;
        run(20);
        clr_now[0] = 1;
        step();

        // enable dropped in WAIT: transaction still finishes
        dmin[0] = 5; dmax[0] = 5;
        for (int i = 0; i < 40; i++) begin
            if (!resolved[0] && cyc == s_at[0] + 1) break;
            step();
        end
        en[0] = 1'b0;
        run(15);
        en[0] = 1'b1;

        // long read on B: next tick dropped, the one after starts
        en[1] = 1'b1; dmin[1] = 19; dmax[1] = 19; rand_data[1] = 1;
        run(45);
        chk("B.overrun_1", 32'(ovr[1]), 1);
        dmin[1] = 2; dmax[1] = 2;
        run(15);
        chk("B.restart", 32'(cnv[1]), 1);
        run(20);
        en[1] = 1'b0;
        run(5);

        // reset asserted while A waits
        dmin[0] = 50; dmax[0] = 50;
        for (int i = 0; i < 40; i++) begin
            if (!resolved[0] && cyc == s_at[0] + 3) break;
            step();
        end
        #2 rst = 1'b0;
        #1;
        check_zero(0); check_zero(1);
        model_reset(0); model_reset(1);
        en[0] = 1'b0;
        run(3);
        rst = 1'b1;
        run(2);
        en[0] = 1'b1; dmin[0] = 3; dmax[0] = 3; rand_data[0] = 1;
        run(20);
        chk("A.first_start_after_rst", 32'(cnv[0]), 1);
        run(40);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
